cobi_scan_ctrl: RTL and testbench

COBI_SCAN_CTRL -- requirements
Module: cobi_scan_ctrl

---
 rtl/cobi_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cobi_scan_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cobi_scan_ctrl.sv
// -----------------------------------------------------------------------------
// cobi_scan_ctrl
//
// Sample-and-scan controller for chains of daisy-chained chips. After a start
// request it pulses the sample strobe, then toggles the scan shift clock while
// capturing one bit per chain on the last cycle of every low phase. Every
// WORD_W captures form a word per chain; the words of all chains are presented
// together on o_DATA through a valid/ready handshake. When the consumer holds
// off, a word-completing capture is postponed and the low phase stretches, so
// the chips never shift past a bit that could not be stored.
//
// Ports
//   i_CLK             system clock, rising edge
//   i_RST             asynchronous active-high reset
//   i_START           start a sample-and-scan (only taken while idle)
//   i_ABORT           cancel the operation in progress
//   o_SAMPLE_CLK      sample strobe to all chips
//   o_SCANOUT_CLK     scan shift clock to all chips
//   i_SCANOUT_DOUT64  serial data from the tail of each chain
//   o_DATA            one word per chain, chain c at [c*WORD_W +: WORD_W]
//   o_VALID/i_READY   handshake for o_DATA
//   o_WORD_IDX        index of the word on o_DATA (0 = first of the scan)
//   o_BUSY            high whenever not idle
//   o_DONE            one-cycle pulse when the scan completes
// -----------------------------------------------------------------------------
module cobi_scan_ctrl #(
  parameter int NUM_CHAINS          = 4,
  parameter int NUM_CHIPS_PER_CHAIN = 1,
  parameter int BITS_PER_CHIP       = 64,
  parameter int WORD_W              = 8,
  parameter int CLK_DIV             = 2,
  parameter int SAMPLE_CYCLES       = 4,
  localparam int NBITS  = NUM_CHIPS_PER_CHAIN * BITS_PER_CHIP,
  localparam int NWORDS = NBITS / WORD_W,
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                         i_CLK,
  input  logic                         i_RST,
  input  logic                         i_START,
  input  logic                         i_ABORT,
  output logic                         o_SAMPLE_CLK,
  output logic                         o_SCANOUT_CLK,
  input  logic [NUM_CHAINS-1:0]        i_SCANOUT_DOUT64,
  output logic [NUM_CHAINS*WORD_W-1:0] o_DATA,
  output logic                         o_VALID,
  input  logic                         i_READY,
  output logic [IDX_W-1:0]             o_WORD_IDX,
  output logic                         o_BUSY,
  output logic                         o_DONE
);

  localparam int CNT_MAX = (CLK_DIV > SAMPLE_CYCLES) ? CLK_DIV : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BCNT_W  = $clog2(NBITS + 1);
  localparam int WB_W    = $clog2(WORD_W + 1);
  localparam int WCNT_W  = $clog2(NWORDS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SAMPLE = 3'd1;
  localparam logic [2:0] S_LOW    = 3'd2;
  localparam logic [2:0] S_HIGH   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [CNT_W-1:0]  cyc;
  logic [BCNT_W-1:0] bit_cnt;
  logic [WB_W-1:0]   bit_in_word;
  logic [WCNT_W-1:0] word_cnt;

  // Only WORD_W-1 earlier bits need storing: the final bit of a word goes
  // straight from the input pins into o_DATA.
  logic [WORD_W-2:0] shreg   [NUM_CHAINS];
  logic [WORD_W-1:0] shifted [NUM_CHAINS];

  logic abort_act;
  logic cap_due;
  logic word_end;
  logic last_bit;
  logic stall;
  logic capture;
  logic load;

  always_comb begin
    abort_act = i_ABORT && (state != S_IDLE);
    cap_due   = (state == S_LOW) && (cyc == CNT_W'(CLK_DIV - 1));
    word_end  = (bit_in_word == WB_W'(WORD_W - 1));
    last_bit  = (bit_cnt == BCNT_W'(NBITS - 1));
    // A word-completing capture needs a free output slot; a slot freed by a
    // handshake in this very cycle counts as free.
    stall     = cap_due && word_end && o_VALID && !i_READY;
    capture   = cap_due && !stall && !abort_act;
    load      = capture && word_end;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      shifted[c] = {shreg[c], i_SCANOUT_DOUT64[c]};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_START && !i_ABORT) state_nxt = S_SAMPLE;
      S_SAMPLE: if (cyc == CNT_W'(SAMPLE_CYCLES - 1)) state_nxt = S_LOW;
      S_LOW:    if (capture) state_nxt = last_bit ? S_DONE : S_HIGH;
      S_HIGH:   if (cyc == CNT_W'(CLK_DIV - 1)) state_nxt = S_LOW;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort_act) state_nxt = S_IDLE;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state         <= S_IDLE;
      cyc           <= '0;
      bit_cnt       <= '0;
      bit_in_word   <= '0;
      word_cnt      <= '0;
      o_SAMPLE_CLK  <= 1'b0;
      o_SCANOUT_CLK <= 1'b0;
      o_BUSY        <= 1'b0;
      o_DONE        <= 1'b0;
      o_VALID       <= 1'b0;
      o_DATA        <= '0;
      o_WORD_IDX    <= '0;
      for (int c = 0; c < NUM_CHAINS; c++) shreg[c] <= '0;
    end else begin
      state <= state_nxt;
      // Outputs are decoded from the next state so they line up with it.
      o_SAMPLE_CLK  <= (state_nxt == S_SAMPLE);
      o_SCANOUT_CLK <= (state_nxt == S_HIGH);
      o_BUSY        <= (state_nxt != S_IDLE);
      o_DONE        <= (state_nxt == S_DONE);

      // Phase counter restarts on every state change and freezes on a stall.
      if (state_nxt != state) begin
        cyc <= '0;
      end else if ((state == S_SAMPLE || state == S_LOW || state == S_HIGH) && !stall) begin
        cyc <= cyc + 1'b1;
      end

      if (abort_act) begin
        bit_cnt     <= '0;
        bit_in_word <= '0;
        word_cnt    <= '0;
        o_VALID     <= 1'b0;
        o_WORD_IDX  <= '0;
        for (int c = 0; c < NUM_CHAINS; c++) shreg[c] <= '0;
      end else begin
        if (state == S_IDLE && state_nxt == S_SAMPLE) begin
          bit_cnt     <= '0;
          bit_in_word <= '0;
          word_cnt    <= '0;
        end

        if (capture) begin
          for (int c = 0; c < NUM_CHAINS; c++) shreg[c] <= shifted[c][WORD_W-2:0];
          bit_cnt     <= bit_cnt + 1'b1;
          bit_in_word <= word_end ? '0 : bit_in_word + 1'b1;
        end

        if (load) begin
          for (int c = 0; c < NUM_CHAINS; c++) o_DATA[c*WORD_W +: WORD_W] <= shifted[c];
          o_WORD_IDX <= IDX_W'(word_cnt);
          word_cnt   <= word_cnt + 1'b1;
          o_VALID    <= 1'b1;
        end else if (o_VALID && i_READY) begin
          o_VALID <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cobi_scan_ctrl.sv
module tb_cobi_scan_ctrl;

  localparam int NC   = 4;
  localparam int W    = 8;
  localparam int NB   = 64;
  localparam int NW   = 8;
  localparam int NC2  = 2;
  localparam int W2   = 16;
  localparam int NB2  = 192;
  localparam int NW2  = 12;
  localparam int MAXC = 1300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start, abort, ready;
  logic [NC-1:0]     dout;
  logic              sample_clk, scan_clk, valid, busy, done;
  logic [NC*W-1:0]   data;
  logic [2:0]        idx;

  logic              start2, abort2, ready2;
  logic [NC2-1:0]    dout2;
  logic              sample2, scan2, valid2, busy2, done2;
  logic [NC2*W2-1:0] data2;
  logic [3:0]        idx2;

  cobi_scan_ctrl dut (
    .i_CLK(clk), .i_RST(rst), .i_START(start), .i_ABORT(abort),
    .o_SAMPLE_CLK(sample_clk), .o_SCANOUT_CLK(scan_clk),
    .i_SCANOUT_DOUT64(dout), .o_DATA(data), .o_VALID(valid), .i_READY(ready),
    .o_WORD_IDX(idx), .o_BUSY(busy), .o_DONE(done)
  );

  cobi_scan_ctrl #(
    .NUM_CHAINS(2), .NUM_CHIPS_PER_CHAIN(3), .BITS_PER_CHIP(64),
    .WORD_W(16), .CLK_DIV(1), .SAMPLE_CYCLES(4)
  ) dut2 (
    .i_CLK(clk), .i_RST(rst), .i_START(start2), .i_ABORT(abort2),
    .o_SAMPLE_CLK(sample2), .o_SCANOUT_CLK(scan2),
    .i_SCANOUT_DOUT64(dout2), .o_DATA(data2), .o_VALID(valid2), .i_READY(ready2),
    .o_WORD_IDX(idx2), .o_BUSY(busy2), .o_DONE(done2)
  );

  int errors = 0;
  int checks = 0;

  // Bit streams held by the chips: the MSB of each vector is shifted out first.
  logic [NB-1:0]  stream  [NC];
  logic [NB2-1:0] stream2 [NC2];

  logic        rec_sample [MAXC];
  logic        rec_scan   [MAXC];
  logic        rec_valid  [MAXC];
  logic        rec_done   [MAXC];
  logic        rec_busy   [MAXC];
  logic [31:0] rec_data   [MAXC];
  logic [2:0]  rec_idx    [MAXC];
  logic [31:0] acc_data [$];
  int          acc_idx  [$];

  function automatic logic [NC*W-1:0] exp_word(int k);
    logic [NC*W-1:0] r;
    for (int c = 0; c < NC; c++) r[c*W +: W] = stream[c][NB-1-k*W -: W];
    return r;
  endfunction

  function automatic logic [NC2*W2-1:0] exp_word2(int k);
    logic [NC2*W2-1:0] r;
    for (int c = 0; c < NC2; c++) r[c*W2 +: W2] = stream2[c][NB2-1-k*W2 -: W2];
    return r;
  endfunction

  task automatic idle(input int n);
    start = 1'b0; abort = 1'b0; ready = 1'b1;
    start2 = 1'b0; ready2 = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Runs ncyc cycles starting with i_START in cycle 0. The chips are modelled
  // as shift registers: the strobe reloads them, each rising scan clock moves
  // to the next bit. Transfers are collected in acc_* in the order taken.
  task automatic run1(input int lo_a, input int lo_b, input bit rnd_ready,
                      input int abort_at, input int start_pulse_at, input int ncyc);
    int   bitpos;
    logic prev_scan;
    acc_data.delete();
    acc_idx.delete();
    bitpos = 0;
    prev_scan = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      rec_sample[n] = sample_clk; rec_scan[n] = scan_clk; rec_valid[n] = valid;
      rec_done[n] = done; rec_busy[n] = busy; rec_data[n] = data; rec_idx[n] = idx;
      if (rnd_ready) ready = ($urandom_range(0, 1) == 1);
      else           ready = !(n >= lo_a && n <= lo_b);
      if (valid && ready) begin
        acc_data.push_back(data);
        acc_idx.push_back(int'(idx));
      end
      if (sample_clk) bitpos = 0;
      else if (scan_clk && !prev_scan) bitpos++;
      prev_scan = scan_clk;
      for (int c = 0; c < NC; c++) dout[c] = (bitpos < NB) ? stream[c][NB-1-bitpos] : 1'b0;
      start = (n == 0) || (n == start_pulse_at);
      abort = (n == abort_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_words(input string tag, input int nexp);
    checks++;
    if (acc_data.size() != nexp) begin
      errors++;
      $display("FAIL %s_count: got %0d words, expected %0d", tag, acc_data.size(), nexp);
    end
    for (int k = 0; k < nexp && k < acc_data.size(); k++) begin
      checks++;
      if (acc_data[k] !== exp_word(k) || acc_idx[k] !== k) begin
        errors++;
        $display("FAIL %s_word%0d: got data %h idx %0d, expected data %h idx %0d",
                 tag, k, acc_data[k], acc_idx[k], exp_word(k), k);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({sample_clk, scan_clk, valid, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 00000", {sample_clk, scan_clk, valid, busy, done});
    end
    checks++;
    if (data !== '0 || idx !== '0) begin
      errors++;
      $display("FAIL reset_data: got data %h idx %0d, expected 0 0", data, idx);
    end
    rst = 1'b0;
    idle(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy %b, expected 0", busy);
    end
  endtask

  task automatic test_default_timing();
    int bad_s, bad_c, bad_d, bad_b;
    stream[0] = {8'hA5, 8'h3C, 16'h0, 32'($urandom)};
    for (int c = 1; c < NC; c++) stream[c] = '0;
    // A start pulse at cycle 50 is issued while busy and must be ignored.
    run1(1, 0, 1'b0, -1, 50, 270);
    bad_s = 0; bad_c = 0; bad_d = 0; bad_b = 0;
    for (int n = 0; n < 270; n++) begin
      if (rec_sample[n] !== (n >= 1 && n <= 4)) bad_s++;
      if (rec_scan[n] !== (n >= 7 && n <= 258 && ((n - 7) % 4) < 2)) bad_c++;
      if (rec_done[n] !== (n == 259)) bad_d++;
      if (rec_busy[n] !== (n >= 1 && n <= 259)) bad_b++;
    end
    checks++;
    if (bad_s != 0) begin errors++; $display("FAIL sample_window: %0d wrong cycles, expected 0", bad_s); end
    checks++;
    if (bad_c != 0) begin errors++; $display("FAIL scanclk_pattern: %0d wrong cycles, expected 0", bad_c); end
    checks++;
    if (bad_d != 0) begin errors++; $display("FAIL done_cycle259: %0d wrong cycles, expected 0", bad_d); end
    checks++;
    if (bad_b != 0) begin errors++; $display("FAIL busy_window: %0d wrong cycles, expected 0", bad_b); end
    checks++;
    if (rec_valid[34] !== 1'b0 || rec_valid[35] !== 1'b1 || rec_data[35] !== 32'h0000_00A5 || rec_idx[35] !== 3'd0) begin
      errors++;
      $display("FAIL word0_at35: got valid %b%b data %h idx %0d, expected valid 01 data 000000a5 idx 0",
               rec_valid[34], rec_valid[35], rec_data[35], rec_idx[35]);
    end
    checks++;
    if (acc_data.size() < 2 || acc_data[1] !== 32'h0000_003C) begin
      errors++;
      $display("FAIL word1_3c: got %h, expected 0000003c", (acc_data.size() < 2) ? 32'hx : acc_data[1]);
    end
    check_words("default", NW);
  endtask

  task automatic test_backpressure();
    int bad_h, bad_c;
    for (int c = 0; c < NC; c++) stream[c] = {32'($urandom), 32'($urandom)};
    run1(30, 120, 1'b0, -1, -1, 330);
    bad_h = 0; bad_c = 0;
    for (int n = 35; n <= 121; n++)
      if (rec_valid[n] !== 1'b1 || rec_data[n] !== exp_word(0) || rec_idx[n] !== 3'd0) bad_h++;
    for (int n = 65; n <= 121; n++) if (rec_scan[n] !== 1'b0) bad_c++;
    checks++;
    if (bad_h != 0) begin errors++; $display("FAIL bp_hold_word0: %0d wrong cycles, expected 0", bad_h); end
    checks++;
    if (bad_c != 0) begin errors++; $display("FAIL bp_scanclk_low: %0d high cycles, expected 0", bad_c); end
    checks++;
    if (rec_valid[122] !== 1'b1 || rec_idx[122] !== 3'd1) begin
      errors++;
      $display("FAIL bp_word1_load: got valid %b idx %0d, expected 1 1", rec_valid[122], rec_idx[122]);
    end
    checks++;
    if (rec_done[313] !== 1'b0 || rec_done[314] !== 1'b1) begin
      errors++;
      $display("FAIL bp_done314: got done %b%b, expected 01", rec_done[313], rec_done[314]);
    end
    check_words("bp", NW);
  endtask

  task automatic test_random_ready();
    int dn;
    for (int c = 0; c < NC; c++) stream[c] = {32'($urandom), 32'($urandom)};
    run1(1, 0, 1'b1, -1, -1, 1200);
    dn = 0;
    for (int n = 0; n < 1200; n++) if (rec_done[n] === 1'b1) dn++;
    checks++;
    if (dn != 1) begin errors++; $display("FAIL rnd_done_count: got %0d, expected 1", dn); end
    check_words("rnd", NW);
  endtask

  task automatic test_final_pending();
    for (int c = 0; c < NC; c++) stream[c] = {32'($urandom), 32'($urandom)};
    run1(240, 280, 1'b0, -1, -1, 300);
    checks++;
    if (rec_done[259] !== 1'b1) begin errors++; $display("FAIL fp_done: got %b, expected 1", rec_done[259]); end
    checks++;
    if (rec_valid[270] !== 1'b1 || rec_idx[270] !== 3'd7 || rec_busy[270] !== 1'b0 || rec_data[270] !== exp_word(7)) begin
      errors++;
      $display("FAIL fp_pending: got valid %b idx %0d busy %b data %h, expected 1 7 0 %h",
               rec_valid[270], rec_idx[270], rec_busy[270], rec_data[270], exp_word(7));
    end
    checks++;
    if (rec_valid[282] !== 1'b0) begin errors++; $display("FAIL fp_drained: got valid %b, expected 0", rec_valid[282]); end
    check_words("fp", NW);
  endtask

  task automatic test_abort();
    int bad;
    for (int c = 0; c < NC; c++) stream[c] = {32'($urandom), 32'($urandom)};
    run1(90, 110, 1'b0, 100, -1, 130);
    checks++;
    if (rec_valid[100] !== 1'b1) begin errors++; $display("FAIL abort_pending: got valid %b, expected 1", rec_valid[100]); end
    bad = 0;
    for (int n = 101; n < 130; n++)
      if ({rec_busy[n], rec_valid[n], rec_sample[n], rec_scan[n]} !== 4'b0) bad++;
    for (int n = 0; n < 130; n++) if (rec_done[n] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_idle: %0d wrong cycles, expected 0", bad); end
    for (int c = 0; c < NC; c++) stream[c] = {32'($urandom), 32'($urandom)};
    run1(1, 0, 1'b0, -1, -1, 270);
    checks++;
    if (rec_done[259] !== 1'b1) begin errors++; $display("FAIL abort_restart_done: got %b, expected 1", rec_done[259]); end
    check_words("restart", NW);
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || sample_clk !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle: got busy %b sample %b, expected 0 0", busy, sample_clk);
    end
    idle(2);
  endtask

  task automatic test_async_reset();
    int bad;
    for (int c = 0; c < NC; c++) stream[c] = {32'($urandom), 32'($urandom)};
    run1(1, 0, 1'b0, -1, -1, 8);
    checks++;
    if (scan_clk !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_in_high: got scan %b busy %b, expected 1 1", scan_clk, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sample_clk, scan_clk, valid, busy, done} !== 5'b0 || data !== '0 || idx !== '0) begin
      errors++;
      $display("FAIL arst_immediate: got ctrl %b data %h idx %0d, expected 00000 0 0",
               {sample_clk, scan_clk, valid, busy, done}, data, idx);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL arst_after: %0d wrong cycles, expected 0", bad); end
  endtask

  task automatic test_config2();
    int bitpos, dn_cnt, dn_cyc, bad_s;
    logic prev;
    logic [31:0] q_data [$];
    int q_idx [$];
    for (int c = 0; c < NC2; c++)
      stream2[c] = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    bitpos = 0; prev = 1'b0; dn_cnt = 0; dn_cyc = -1; bad_s = 0;
    for (int n = 0; n < 400; n++) begin
      if (done2 === 1'b1) begin dn_cnt++; dn_cyc = n; end
      if (sample2 !== (n >= 1 && n <= 4)) bad_s++;
      ready2 = 1'b1;
      if (valid2 && ready2) begin q_data.push_back(data2); q_idx.push_back(int'(idx2)); end
      if (sample2) bitpos = 0;
      else if (scan2 && !prev) bitpos++;
      prev = scan2;
      for (int c = 0; c < NC2; c++) dout2[c] = (bitpos < NB2) ? stream2[c][NB2-1-bitpos] : 1'b0;
      start2 = (n == 0);
      @(posedge clk); #1;
    end
    start2 = 1'b0;
    checks++;
    if (bad_s != 0) begin errors++; $display("FAIL cfg2_sample: %0d wrong cycles, expected 0", bad_s); end
    checks++;
    if (dn_cnt != 1 || dn_cyc != 388) begin
      errors++;
      $display("FAIL cfg2_done: got %0d pulses at %0d, expected 1 at 388", dn_cnt, dn_cyc);
    end
    checks++;
    if (q_data.size() != NW2) begin errors++; $display("FAIL cfg2_count: got %0d, expected %0d", q_data.size(), NW2); end
    for (int k = 0; k < NW2 && k < q_data.size(); k++) begin
      checks++;
      if (q_data[k] !== exp_word2(k) || q_idx[k] !== k) begin
        errors++;
        $display("FAIL cfg2_word%0d: got data %h idx %0d, expected data %h idx %0d",
                 k, q_data[k], q_idx[k], exp_word2(k), k);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; abort = 1'b0; ready = 1'b1; dout = '0;
    start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b1; dout2 = '0;
    #1;
    test_reset();
    test_default_timing();
    idle(5);
    test_backpressure();
    idle(5);
    test_random_ready();
    idle(5);
    test_final_pending();
    idle(5);
    test_abort();
    idle(5);
    test_start_abort_idle();
    test_async_reset();
    idle(3);
    test_config2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
